// File: rtl/board_keeper_pkg.sv
// Shared encodings, sizes and the win-line table for the board keeper.
package board_keeper_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned CELL_W    = 4;
    localparam int unsigned MARK_W    = 2;

    localparam logic [MARK_W-1:0] EMPTY  = 2'b00;
    localparam logic [MARK_W-1:0] MARK_X = 2'b10;
    localparam logic [MARK_W-1:0] MARK_O = 2'b01;

    localparam logic [CELL_W-1:0] NO_CELL = 4'hF;

    typedef logic [CELL_W-1:0]                 cell_idx_t;
    typedef logic [NUM_CELLS-1:0][MARK_W-1:0]  board_t;

    // Cell indices of every row, column and diagonal.
    localparam logic [NUM_LINES-1:0][2:0][CELL_W-1:0] WIN_LINES = {
        {4'd2, 4'd4, 4'd6},
        {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd5, 4'd8},
        {4'd1, 4'd4, 4'd7},
        {4'd0, 4'd3, 4'd6},
        {4'd6, 4'd7, 4'd8},
        {4'd3, 4'd4, 4'd5},
        {4'd0, 4'd1, 4'd2}
    };

    // Owner of a line, or EMPTY when the line is not complete.
    function automatic logic [MARK_W-1:0] line_mark(board_t b, logic [2:0] l);
        logic [MARK_W-1:0] c0, c1, c2;
        c0 = b[WIN_LINES[l][0]];
        c1 = b[WIN_LINES[l][1]];
        c2 = b[WIN_LINES[l][2]];
        return (c0 != EMPTY && c0 == c1 && c1 == c2) ? c0 : EMPTY;
    endfunction

endpackage

// File: rtl/board_keeper_if.sv
// Move input and board/state outputs of the board keeper.
interface board_keeper_if;
    import board_keeper_pkg::*;

    cell_idx_t         location;
    logic [MARK_W-1:0] mark;
    logic [MARK_W-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
    logic [MARK_W-1:0] gameend;
    cell_idx_t         fade_x;
    cell_idx_t         fade_o;

    modport master (
        output location, mark,
        input  a0, a1, a2, a3, a4, a5, a6, a7, a8, gameend, fade_x, fade_o
    );

    modport slave (
        input  location, mark,
        output a0, a1, a2, a3, a4, a5, a6, a7, a8, gameend, fade_x, fade_o
    );
endinterface

// File: rtl/board_keeper_mark_fifo.sv
// KEEP-deep oldest-first queue of cell positions owned by one player.
module mark_fifo
    import board_keeper_pkg::*;
#(
    parameter int unsigned KEEP = 3,
    localparam int unsigned CW  = $clog2(KEEP + 1),
    localparam int unsigned IW  = (KEEP > 1) ? $clog2(KEEP) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  cell_idx_t     din,
    output cell_idx_t     head,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [KEEP-1:0][CELL_W-1:0] q, q_next;
    logic [KEEP:0][CELL_W-1:0]   ext;
    logic [CW-1:0]               count_next;
    logic [CW-1:0]               wr_idx;
    logic                        do_push;

    assign ext     = {NO_CELL, q};
    assign full    = (count == CW'(KEEP));
    assign head    = q[0];
    assign do_push = push && (pop || !full);

    // Pop shifts toward the head; push lands just behind the last live entry.
    always_comb begin
        q_next     = q;
        count_next = count;
        wr_idx     = pop ? (count - CW'(1)) : count;
        if (pop) begin
            for (int unsigned i = 0; i < KEEP; i++) begin
                q_next[IW'(i)] = ext[CW'(i + 1)];
            end
        end
        if (do_push) begin
            for (int unsigned i = 0; i < KEEP; i++) begin
                if (CW'(i) == wr_idx) begin
                    q_next[IW'(i)] = din;
                end
            end
        end
        if (do_push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !do_push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= {KEEP{NO_CELL}};
            count <= '0;
        end else begin
            q     <= q_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/board_keeper.sv
// Tic-tac-toe board with a bounded number of marks per player and sticky win detection.
module board_keeper
    import board_keeper_pkg::*;
#(
    parameter int unsigned KEEP = 3
) (
    input  logic           clk,
    input  logic           rst,
    board_keeper_if.slave  bus
);

    localparam int unsigned CW = $clog2(KEEP + 1);

    logic [MARK_W+CELL_W-1:0] prev;
    board_t                   board, board_next;
    logic [MARK_W-1:0]        gameend_q, gameend_next;
    logic                     x_win_c, o_win_c;
    logic                     target_empty_c, accept_c, is_x_c;
    logic                     push_x, push_o, pop_x, pop_o;
    cell_idx_t                head_x, head_o;
    logic [CW-1:0]            count_x, count_o;
    logic                     full_x, full_o;

    mark_fifo #(.KEEP(KEEP)) u_fifo_x (
        .clk(clk), .rst(rst), .push(push_x), .pop(pop_x), .din(bus.location),
        .head(head_x), .count(count_x), .full(full_x)
    );

    mark_fifo #(.KEEP(KEEP)) u_fifo_o (
        .clk(clk), .rst(rst), .push(push_o), .pop(pop_o), .din(bus.location),
        .head(head_o), .count(count_o), .full(full_o)
    );

    always_comb begin
        target_empty_c = 1'b0;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (bus.location == CELL_W'(c)) begin
                target_empty_c = (board[CELL_W'(c)] == EMPTY);
            end
        end
    end

    always_comb begin
        x_win_c = 1'b0;
        o_win_c = 1'b0;
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
            if (line_mark(board, 3'(l)) == MARK_X) x_win_c = 1'b1;
            if (line_mark(board, 3'(l)) == MARK_O) o_win_c = 1'b1;
        end
    end

    // A win visible on the board blocks moves in the same cycle gameend is set.
    assign is_x_c   = (bus.mark == MARK_X);
    assign accept_c = (bus.mark == MARK_X || bus.mark == MARK_O)
                   && ({bus.mark, bus.location} != prev)
                   && (bus.location <= CELL_W'(NUM_CELLS - 1))
                   && target_empty_c
                   && (gameend_q == EMPTY)
                   && !x_win_c && !o_win_c;

    assign push_x = accept_c && is_x_c;
    assign push_o = accept_c && !is_x_c;
    assign pop_x  = push_x && full_x;
    assign pop_o  = push_o && full_o;

    always_comb begin
        board_next = board;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if ((pop_x && head_x == CELL_W'(c)) || (pop_o && head_o == CELL_W'(c))) begin
                board_next[CELL_W'(c)] = EMPTY;
            end
            if (accept_c && bus.location == CELL_W'(c)) begin
                board_next[CELL_W'(c)] = bus.mark;
            end
        end
    end

    always_comb begin
        gameend_next = gameend_q;
        if (gameend_q == EMPTY) begin
            if (x_win_c)      gameend_next = MARK_X;
            else if (o_win_c) gameend_next = MARK_O;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            board     <= '0;
            gameend_q <= EMPTY;
        end else begin
            prev      <= {bus.mark, bus.location};
            board     <= board_next;
            gameend_q <= gameend_next;
        end
    end

    assign bus.a0      = board[0];
    assign bus.a1      = board[1];
    assign bus.a2      = board[2];
    assign bus.a3      = board[3];
    assign bus.a4      = board[4];
    assign bus.a5      = board[5];
    assign bus.a6      = board[6];
    assign bus.a7      = board[7];
    assign bus.a8      = board[8];
    assign bus.gameend = gameend_q;
    assign bus.fade_x  = (count_x == CW'(KEEP)) ? head_x : NO_CELL;
    assign bus.fade_o  = (count_o == CW'(KEEP)) ? head_o : NO_CELL;

endmodule
